sem_cfg_master: RTL

//  Bus initiator that programs one railway-crossing semaphore through its two slave ports.
//  On start: stops the semaphore, streams 16 period words into its period RAM, then writes the

---
 rtl/sem_cfg_master.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sem_cfg_master.sv
// Bus initiator that stops a railway-crossing semaphore, reloads its period RAM,
// programs divider and run bits, then reads both control registers back to verify them.
module sem_cfg_master #(
  parameter int unsigned WORDS   = 16,
  parameter int unsigned M       = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [1:0]  div_sel,
  input  logic        run_en,
  input  logic        src_valid,
  input  logic [31:0] src_data,
  output logic        src_ready,
  output logic        ctl_wr,
  output logic        ctl_rd,
  output logic        ctl_addr,
  output logic [31:0] ctl_wrdata,
  input  logic [31:0] ctl_rddata,
  output logic        ram_wr,
  output logic [3:0]  ram_addr,
  output logic [31:0] ram_wrdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        sat
);

  localparam int unsigned AW = 4;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] SAT_MAX = 32'((64'(1) << M) - 64'(1));

  typedef enum logic [3:0] {
    S_IDLE, S_STOP, S_LOAD, S_DIV, S_RUNW, S_CHK0, S_CHK1, S_DONE, S_ERR
  } state_t;

  state_t        state;
  logic [1:0]    div_q;
  logic          run_q;
  logic [AW-1:0] wc;
  logic [TW-1:0] idle;

  logic          hs;
  logic          over;
  logic [31:0]   sat_data;

  // RAM port is driven straight from the handshake so each accepted word lands the same cycle
  assign hs         = (state == S_LOAD) && src_ready && src_valid;
  assign over       = (src_data >> M) != 32'd0;
  assign sat_data   = over ? SAT_MAX : src_data;
  assign ram_wr     = hs;
  assign ram_addr   = hs ? wc : '0;
  assign ram_wrdata = hs ? sat_data : '0;

  // Sequencer; outputs are loaded together with the state they belong to
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= S_IDLE;
      div_q      <= '0;
      run_q      <= 1'b0;
      wc         <= '0;
      idle       <= '0;
      src_ready  <= 1'b0;
      ctl_wr     <= 1'b0;
      ctl_rd     <= 1'b0;
      ctl_addr   <= 1'b0;
      ctl_wrdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      sat        <= 1'b0;
    end else begin
      ctl_wr     <= 1'b0;
      ctl_rd     <= 1'b0;
      ctl_addr   <= 1'b0;
      ctl_wrdata <= '0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            div_q  <= div_sel;
            run_q  <= run_en;
            error  <= 1'b0;
            sat    <= 1'b0;
            busy   <= 1'b1;
            ctl_wr <= 1'b1;
            state  <= S_STOP;
          end
        end
        S_STOP: begin
          src_ready <= 1'b1;
          wc        <= '0;
          idle      <= '0;
          state     <= S_LOAD;
        end
        S_LOAD: begin
          if (hs) begin
            idle <= '0;
            wc   <= wc + 1'b1;
            if (over) sat <= 1'b1;
            if (wc == AW'(WORDS - 1)) begin
              src_ready  <= 1'b0;
              ctl_wr     <= 1'b1;
              ctl_addr   <= 1'b1;
              ctl_wrdata <= {30'b0, div_q};
              state      <= S_DIV;
            end
          end else if (!src_valid) begin
            if (idle == TW'(TIMEOUT - 1)) begin
              src_ready <= 1'b0;
              ctl_wr    <= 1'b1;
              error     <= 1'b1;
              state     <= S_ERR;
            end else begin
              idle <= idle + 1'b1;
            end
          end
        end
        S_DIV: begin
          ctl_wr     <= 1'b1;
          ctl_wrdata <= {31'b0, run_q};
          state      <= S_RUNW;
        end
        S_RUNW: begin
          ctl_rd <= 1'b1;
          state  <= S_CHK0;
        end
        S_CHK0: begin
          if (ctl_rddata[0] != run_q) begin
            ctl_wr <= 1'b1;
            error  <= 1'b1;
            state  <= S_ERR;
          end else begin
            ctl_rd   <= 1'b1;
            ctl_addr <= 1'b1;
            state    <= S_CHK1;
          end
        end
        S_CHK1: begin
          if (ctl_rddata[1:0] != div_q) begin
            ctl_wr <= 1'b1;
            error  <= 1'b1;
            state  <= S_ERR;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
